// File: rtl/ccsds_turbo_enc_sched_pkg.sv
// Shared constants for the CCSDS turbo encoder scheduler.
// - cCODE_* : 2-bit code-rate encodings carried on icode/ocode
// - sched_state_e : scheduler FSM states
// - code_period() : cycles per trellis step for a given rate
package ccsds_turbo_enc_sched_pkg;

  localparam logic [1:0] cCODE_1by2 = 2'd0;
  localparam logic [1:0] cCODE_1by3 = 2'd1;
  localparam logic [1:0] cCODE_1by4 = 2'd2;
  localparam logic [1:0] cCODE_1by6 = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } sched_state_e;

  // One trellis step emits 1/rate serial bits, so the step period equals the rate denominator.
  function automatic logic [2:0] code_period(input logic [1:0] code);
    logic [2:0] p;
    unique case (code)
      cCODE_1by2: p = 3'd2;
      cCODE_1by3: p = 3'd3;
      cCODE_1by4: p = 3'd4;
      default:    p = 3'd6;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ccsds_turbo_enc_sched_if.sv
// Frame control / strobe bundle of the turbo encoder scheduler.
// master: frame-level controller (drives iclkena/istart/icode/ilen, observes the rest)
// slave : the scheduler itself
interface ccsds_turbo_enc_sched_if #(
  parameter int unsigned pW_LEN = 14
) ();
  logic              iclkena;
  logic              istart;
  logic [1:0]        icode;
  logic [pW_LEN-1:0] ilen;
  logic              obusy;
  logic              ostep;
  logic [pW_LEN-1:0] oidx;
  logic              otail;
  logic              osop;
  logic              oval;
  logic              oeop;
  logic [1:0]        ocode;
  logic              odone;
  logic              oerr;

  modport master (
    output iclkena, istart, icode, ilen,
    input  obusy, ostep, oidx, otail, osop, oval, oeop, ocode, odone, oerr
  );

  modport slave (
    input  iclkena, istart, icode, ilen,
    output obusy, ostep, oidx, otail, osop, oval, oeop, ocode, odone, oerr
  );
endinterface

// File: rtl/ccsds_turbo_enc_sched_dline.sv
// Enable-gated 3-bit delay line aligning {eop, sop, step} with the encoder output.
// clk_i/rst_ni : clock, asynchronous active-low clear
// en_i         : shift enable (holds contents when low)
// d_i / q_o    : input strobes / strobes delayed by Depth cycles (Depth=0 is a wire)
module ccsds_turbo_enc_sched_dline #(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  if (Depth == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_pipe
    logic [2:0] pipe_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
      end else if (en_i) begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[Depth-1];
  end

endmodule

// File: rtl/ccsds_turbo_enc_sched.sv
// CCSDS turbo encoder frame scheduler.
// Accepts a frame request, latches rate/length, then issues one trellis step every P cycles
// (k info steps + 4 tail steps), delays step/sop/eop by pENC_LAT for the puncture stage, drains
// the last serial bits and pulses odone. Illegal lengths are rejected with a oerr pulse.
// iclk/ireset_n : clock, asynchronous active-low reset
// bus (slave)   : iclkena/istart/icode/ilen in; obusy/ostep/oidx/otail/osop/oval/oeop/ocode/
//                 odone/oerr out
module ccsds_turbo_enc_sched
  import ccsds_turbo_enc_sched_pkg::*;
#(
  parameter int unsigned pW_LEN   = 14,
  parameter int unsigned pN_MAX   = 8920,
  parameter int unsigned pENC_LAT = 1
) (
  input logic                     iclk,
  input logic                     ireset_n,
  ccsds_turbo_enc_sched_if.slave  bus
);

  localparam logic [pW_LEN-1:0] NMax      = pW_LEN'(pN_MAX);
  localparam logic [3:0]        DrainLast = 4'(pENC_LAT);

  sched_state_e      state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic [pW_LEN-1:0] len_q, len_d;
  logic [pW_LEN-1:0] idx_q, idx_d;
  logic [2:0]        pcnt_q, pcnt_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic              err_q, err_d;

  logic              len_ok;
  logic [2:0]        per_last;
  logic [pW_LEN-1:0] idx_last;
  logic              step;
  logic [2:0]        dl_in, dl_out;

  assign len_ok   = (bus.ilen != '0) && (bus.ilen <= NMax);
  assign per_last = code_period(code_q) - 3'd1;
  assign idx_last = len_q + pW_LEN'(3);
  assign step     = (state_q == StRun) && (pcnt_q == '0);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.istart) begin
          if (len_ok) begin
            code_d  = bus.icode;
            len_d   = bus.ilen;
            idx_d   = '0;
            pcnt_d  = '0;
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        // idx is held for the whole period so it stays aligned with the step strobe
        if (pcnt_q == per_last) begin
          pcnt_d = '0;
          if (idx_q == idx_last) begin
            dcnt_d  = '0;
            state_d = StDrain;
          end else begin
            idx_d = idx_q + pW_LEN'(1);
          end
        end else begin
          pcnt_d = pcnt_q + 3'd1;
        end
      end
      StDrain: begin
        // Last serial bit of the final step leaves the serializer pENC_LAT cycles from here
        if (dcnt_q == DrainLast) begin
          state_d = StIdle;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else if (bus.iclkena) begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  assign dl_in = {step && (idx_q == idx_last), step && (idx_q == '0), step};

  ccsds_turbo_enc_sched_dline #(
    .Depth (pENC_LAT)
  ) u_dline (
    .clk_i  (iclk),
    .rst_ni (ireset_n),
    .en_i   (bus.iclkena),
    .d_i    (dl_in),
    .q_o    (dl_out)
  );

  assign bus.obusy = (state_q != StIdle);
  assign bus.ostep = step;
  assign bus.oidx  = step ? idx_q : '0;
  assign bus.otail = step && (idx_q >= len_q);
  assign bus.oval  = dl_out[0];
  assign bus.osop  = dl_out[1];
  assign bus.oeop  = dl_out[2];
  assign bus.ocode = code_q;
  assign bus.odone = (state_q == StDrain) && (dcnt_q == DrainLast);
  assign bus.oerr  = err_q;

endmodule

// File: tb/tb_ccsds_turbo_enc_sched.sv
module tb_ccsds_turbo_enc_sched;
  localparam int unsigned W    = 14;
  localparam int unsigned NMAX = 8920;
  localparam int          LAT  = 1;

  logic iclk = 1'b0;
  logic ireset_n = 1'b0;

  ccsds_turbo_enc_sched_if #(.pW_LEN(W)) bus ();

  ccsds_turbo_enc_sched #(
    .pW_LEN   (W),
    .pN_MAX   (NMAX),
    .pENC_LAT (LAT)
  ) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .bus      (bus)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int passed = 0;

  // Reference model: frame described by accept time, k and P; outputs derived arithmetically.
  int         eff = 0;
  int         cyc = 0;
  bit         have = 0;
  int         fa = 0, fk = 0, fp = 2;
  logic [1:0] last_code = 2'd0;
  bit         err_have = 0;
  int         err_e = 0;

  // Per-request statistics from DUT outputs (times relative to the request cycle)
  int n_step, n_tail, n_val, sop_rel, eop_rel, done_rel, err_rel, n_err;
  int err_total = 0;
  int req_abs = 0;
  int n_acc = 0;
  int acc_hist [8];
  bit got_done = 0;

  function automatic int per_of(input logic [1:0] c);
    case (c)
      2'd0:    return 2;
      2'd1:    return 3;
      2'd2:    return 4;
      default: return 6;
    endcase
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic clear_stats();
    n_step = 0; n_tail = 0; n_val = 0; n_err = 0;
    sop_rel = -1; eop_rel = -1; done_rel = -1; err_rel = -1;
    got_done = 0;
  endtask

  // Called at the falling edge: compare, gather stats, then advance the model.
  task automatic step_model();
    logic [23:0] act, exp;
    bit e_busy, e_step, e_tail, e_sop, e_val, e_eop, e_done, e_err, idle_m;
    int t, tv, endt, e_idx, jv, rel, len_i;
    logic [1:0] e_code;
    e_busy = 0; e_step = 0; e_tail = 0; e_sop = 0; e_val = 0; e_eop = 0; e_done = 0;
    e_idx = 0;
    if (ireset_n && have) begin
      t    = eff - fa;
      endt = 1 + (fk + 4) * fp + LAT;
      e_busy = (t >= 1) && (t <= endt);
      e_done = (t == endt);
      if (t >= 1 && (t - 1) % fp == 0 && (t - 1) / fp < fk + 4) begin
        e_step = 1;
        e_idx  = (t - 1) / fp;
        e_tail = (e_idx >= fk);
      end
      tv = t - LAT;
      if (tv >= 1 && (tv - 1) % fp == 0 && (tv - 1) / fp < fk + 4) begin
        jv    = (tv - 1) / fp;
        e_val = 1;
        e_sop = (jv == 0);
        e_eop = (jv == fk + 3);
      end
    end
    e_err  = ireset_n && err_have && (eff == err_e + 1);
    e_code = ireset_n ? last_code : 2'd0;

    act = {bus.obusy, bus.ostep, e_step ? bus.otail : 1'b0, e_step ? bus.oidx : 14'd0,
           bus.osop, bus.oval, bus.oeop, bus.ocode, bus.odone, bus.oerr};
    exp = {e_busy, e_step, e_tail, 14'(e_idx), e_sop, e_val, e_eop, e_code, e_done, e_err};
    checks++;
    if (act === exp) passed++;
    else $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act, exp);

    if (ireset_n && bus.iclkena) begin
      rel = cyc - req_abs;
      if (bus.ostep) n_step++;
      if (bus.ostep && bus.otail) n_tail++;
      if (bus.oval) n_val++;
      if (bus.osop && sop_rel < 0) sop_rel = rel;
      if (bus.oeop && eop_rel < 0) eop_rel = rel;
      if (bus.odone) begin done_rel = rel; got_done = 1; end
      if (bus.oerr) begin n_err++; err_total++; err_rel = rel; end
    end

    if (!ireset_n) begin
      have = 0; err_have = 0; last_code = 2'd0;
    end else if (bus.iclkena) begin
      idle_m = !have || ((eff - fa) > 1 + (fk + 4) * fp + LAT);
      if (idle_m && bus.istart) begin
        req_abs = cyc;
        clear_stats();
        len_i = int'(bus.ilen);
        if (len_i != 0 && len_i <= NMAX) begin
          have = 1; fa = eff; fk = len_i; fp = per_of(bus.icode); last_code = bus.icode;
          acc_hist[n_acc % 8] = cyc;
          n_acc++;
        end else begin
          err_have = 1; err_e = eff;
        end
      end
      eff++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge iclk);
    step_model();
    @(posedge iclk);
    #1;
  endtask

  task automatic start(input logic [1:0] code, input int len);
    bus.istart = 1'b1;
    bus.icode  = code;
    bus.ilen   = W'(len);
    tick();
    bus.istart = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !got_done; i++) tick();
    check("done_seen", int'(got_done), 1);
    repeat (2) tick();
  endtask

  int a0, e0;

  initial begin
    bus.iclkena = 1'b1;
    bus.istart  = 1'b0;
    bus.icode   = 2'd0;
    bus.ilen    = '0;
    clear_stats();
    repeat (3) tick();
    ireset_n = 1'b1;
    repeat (2) tick();

    // Rate 1/2, k=16
    start(2'd0, 16);
    wait_done(100);
    check("r2_steps", n_step, 20);
    check("r2_tail", n_tail, 4);
    check("r2_vals", n_val, 20);
    check("r2_sop", sop_rel, 2);
    check("r2_eop", eop_rel, 40);
    check("r2_done", done_rel, 42);

    // Rate 1/6, k=16, icode scrambled during the frame
    start(2'd3, 16);
    for (int i = 0; i < 200 && !got_done; i++) begin
      bus.icode = 2'($urandom_range(0, 3));
      tick();
    end
    check("r6_done_seen", int'(got_done), 1);
    repeat (2) tick();
    check("r6_done", done_rel, 122);
    check("r6_steps", n_step, 20);
    check("r6_eop", eop_rel, 116);

    // Illegal lengths
    start(2'd0, 0);
    repeat (3) tick();
    check("len0_err", n_err, 1);
    check("len0_err_t", err_rel, 1);
    check("len0_steps", n_step, 0);
    start(2'd1, NMAX + 1);
    repeat (3) tick();
    check("lenmax_err", n_err, 1);
    check("lenmax_err_t", err_rel, 1);
    check("lenmax_steps", n_step, 0);

    // Minimal frame k=1
    start(2'd0, 1);
    wait_done(40);
    check("k1_steps", n_step, 5);
    check("k1_tail", n_tail, 4);
    check("k1_done", done_rel, 12);

    // istart held high, rate 1/3: back-to-back frames
    a0 = n_acc;
    e0 = err_total;
    bus.istart = 1'b1;
    bus.icode  = 2'd1;
    bus.ilen   = W'(16);
    for (int i = 0; i < 200 && n_acc < a0 + 2; i++) tick();
    bus.istart = 1'b0;
    check("b2b_accepts", n_acc - a0, 2);
    check("b2b_gap", acc_hist[(n_acc - 1) % 8] - acc_hist[(n_acc - 2) % 8], 63);
    wait_done(200);
    check("b2b_done", done_rel, 62);
    check("b2b_noerr", err_total - e0, 0);

    // Clock enable low for 3 cycles after step 5, rate 1/4
    start(2'd2, 16);
    repeat (22) tick();
    bus.iclkena = 1'b0;
    repeat (3) tick();
    bus.iclkena = 1'b1;
    wait_done(150);
    check("ce_steps", n_step, 20);
    check("ce_sop", sop_rel, 2);
    check("ce_eop", eop_rel, 81);
    check("ce_done", done_rel, 85);

    // Reset at step 10, then a normal frame
    start(2'd0, 16);
    repeat (20) tick();
    ireset_n = 1'b0;
    repeat (2) tick();
    ireset_n = 1'b1;
    repeat (3) tick();
    check("rst_steps", n_step, 10);
    check("rst_nodone", int'(got_done), 0);
    start(2'd0, 16);
    wait_done(100);
    check("post_steps", n_step, 20);
    check("post_done", done_rel, 42);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ccsds_turbo_enc_sched.md
# ccsds_turbo_enc_sched

Frame scheduler for the CCSDS turbo encoder output stage. On a frame request it latches code rate and information length, then paces the constituent encoders and the puncture/serializer stage: one trellis-step strobe every P cycles (P = 2/3/4/6 for rates 1/2, 1/3, 1/4, 1/6), plus sop/val/eop/code for the puncture stage, delayed to match encoder latency. It sits between the frame-level control and the encoder/puncture datapath and guarantees the serializer is never overrun.

## Interface
- pW_LEN, 14: width of the length and index fields.
- pN_MAX, 8920: largest legal information length k.
- pENC_LAT, 1: encoder latency in cycles from ostep to its registered symbol (0..7).
- iclk  in  1  clock
- ireset_n  in  1  asynchronous, active-low reset
- iclkena  in  1  clock enable; all state holds when low
- istart  in  1  frame request, sampled when not busy
- icode  in  2  code rate (cCODE_1by2/1by3/1by4/1by6), latched on accepted istart
- ilen  in  pW_LEN  information length k, latched on accepted istart
- obusy  out  1  frame in progress
- ostep  out  1  advance encoders one trellis step
- oidx  out  pW_LEN  step index, valid with ostep (0..k+3)
- otail  out  1  with ostep: termination step (oidx >= k)
- osop, oval, oeop  out  1  puncture-stage strobes, ostep delayed pENC_LAT
- ocode  out  2  latched rate, stable for the whole frame
- odone  out  1  one-cycle pulse: last serial bit drained
- oerr  out  1  one-cycle pulse: request rejected (ilen==0 or ilen>pN_MAX)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: istart with legal ilen -> latch code/len, clear idx and period counter, go RUN. Illegal ilen -> oerr, stay IDLE.
- RUN: period counter 0..P-1; ostep when counter==0, oidx=idx; idx increments after each step. Total steps k+4 (4 tail). After step k+3 -> DRAIN.
- DRAIN: count pENC_LAT+P cycles, then odone, -> IDLE.
- osop with the step-0 delayed oval; oeop with the step-(k+3) delayed oval. Exactly k+4 oval pulses per frame.
- istart while busy (including the odone cycle): ignored, no oerr.
- Delay line holds ostep/sop/eop; pENC_LAT=0 makes oval combinationally equal to ostep.
- iclkena low: counters, FSM and delay line freeze; strobes only held high if they were high, with no new events.

## Timing
- Reset: obusy, ostep, oidx, otail, osop, oval, oeop, odone, oerr = 0; ocode = 0; FSM IDLE.
- istart accepted at cycle 0: obusy=1 from cycle 1; step j at cycle 1+j·P; oval at 1+j·P+pENC_LAT.
- odone at cycle 1+(k+4)·P+pENC_LAT. obusy is high through the odone cycle and low the next cycle. The next istart can be accepted then.
- oerr is asserted at cycle 1 and obusy stays 0.
- Reset mid-frame: immediate return to reset values; no odone; in-flight delayed strobes dropped.
- Period and step counters never wrap: idx max k+3 ≤ pN_MAX+3 fits pW_LEN.

## Structure
- Rate constants (cCODE_*) and a function code->P (2,3,4,6) go in the shared ccsds_turbo parameters package. Do not hard-code them locally.
- One sub-module: ccsds_turbo_enc_sched_dline, a parameterised depth-pENC_LAT, 3-bit-wide enable-gated shift register with asynchronous clear.
- Top level: FSM, period counter, step counter, drain counter, about 200 lines.

## Test plan
- Rate 1/2, k=16, pENC_LAT=1: 20 osteps at cycles 1,3,...,39; osop with oval at cycle 2, oeop at 40; otail for oidx 16..19; odone at 42.
- Rate 1/6, k=16: osteps every 6 cycles; odone at 122; ocode stays cCODE_1by6 throughout while icode is toggled.
- ilen=0 and ilen=pN_MAX+1: oerr at cycle 1, no ostep, obusy=0.
- istart held high continuously, rate 1/3, k=16: second frame accepted the cycle after odone; istart during busy causes no oerr.
- iclkena low for 3 cycles after step 5, rate 1/4: every subsequent event is shifted exactly +3 cycles and the step count is unchanged.
- ireset_n asserted at step 10: all outputs 0 asynchronously, no odone; the next frame runs normally.
